// File: rtl/minterm_pkg.sv
// Shared types for the minterm sweeper: FSM state encoding and the
// minterm-count helper used to size the truth table.
package minterm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic int n_minterms(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/sweep_counter.sv
// N-bit minterm index counter with synchronous clear, count enable and a
// terminal-count flag marking the last minterm.
module sweep_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count,
  output logic             o_tc
);

  logic [WIDTH-1:0] r_count;

  // NOTE: clocked state is written with non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;
  assign o_tc    = &r_count;

endmodule

// File: rtl/minterm_sweeper.sv
// Programmable N-input Boolean function evaluator: sweeps every minterm of a
// runtime-loadable truth table and accumulates ON-set size and lowest ON index.
module minterm_sweeper
  import minterm_pkg::*;
#(
  parameter int                   N_IN    = 4,
  parameter logic [(1<<N_IN)-1:0] TT_INIT = 16'hEEE0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 step_en,
  input  logic                 tt_load,
  input  logic [(1<<N_IN)-1:0] tt_in,
  output logic [N_IN-1:0]      in_vec,
  output logic                 q,
  output logic [N_IN-1:0]      q_idx,
  output logic                 q_valid,
  output logic                 busy,
  output logic                 done,
  output logic [N_IN:0]        ones_count,
  output logic                 found,
  output logic [N_IN-1:0]      first_one
);

  localparam int N_MINTERMS = n_minterms(N_IN);
  localparam int CW         = N_IN + 1;

  state_e                  r_state;
  state_e                  w_next_state;
  logic [N_MINTERMS-1:0]   r_table;
  logic                    r_q;
  logic [N_IN-1:0]         r_q_idx;
  logic                    r_q_valid;
  logic [N_IN:0]           r_ones_count;
  logic                    r_found;
  logic [N_IN-1:0]         r_first_one;

  logic                    w_step;
  logic                    w_clear;
  logic                    w_last;
  logic                    w_bit;
  logic [N_IN-1:0]         w_in_vec;
  logic                    w_busy;
  logic                    w_done;

  assign w_step  = (r_state == ST_SWEEP) && step_en;
  assign w_clear = (r_state == ST_IDLE) && start;
  assign w_bit   = r_table[w_in_vec];

  sweep_counter #(
    .WIDTH (N_IN)
  ) u_counter (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (w_clear),
    .i_en    (w_step),
    .o_count (w_in_vec),
    .o_tc    (w_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every signal driven here gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) w_next_state = ST_SWEEP;
      end
      ST_SWEEP: begin
        w_busy = 1'b1;
        if (w_step && w_last) w_next_state = ST_DONE;
      end
      ST_DONE: begin
        w_done       = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // NOTE: the truth table is a plain register, not a RAM, so it is reset to
  // TT_INIT like any other state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_table      <= TT_INIT;
      r_q          <= 1'b0;
      r_q_idx      <= '0;
      r_q_valid    <= 1'b0;
      r_ones_count <= '0;
      r_found      <= 1'b0;
      r_first_one  <= '0;
    end else begin
      r_q_valid <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          // A load coincident with start lands before the first step reads the table.
          if (tt_load) r_table <= tt_in;
          if (start) begin
            r_ones_count <= '0;
            r_found      <= 1'b0;
            r_first_one  <= '0;
          end
        end
        ST_SWEEP: begin
          if (step_en) begin
            r_q       <= w_bit;
            r_q_idx   <= w_in_vec;
            r_q_valid <= 1'b1;
            if (w_bit) begin
              r_ones_count <= r_ones_count + CW'(1);
              if (!r_found) begin
                r_found     <= 1'b1;
                r_first_one <= w_in_vec;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign in_vec     = w_in_vec;
  assign q          = r_q;
  assign q_idx      = r_q_idx;
  assign q_valid    = r_q_valid;
  assign busy       = w_busy;
  assign done       = w_done;
  assign ones_count = r_ones_count;
  assign found      = r_found;
  assign first_one  = r_first_one;

endmodule
